// File: rtl/sram_loader.sv
// Boot-time loader: streams bytes into the shared 256x8 SRAM over the cen/wen/oen/dq bus,
// optionally reads the image back to confirm its checksum, and holds the core in reset until then.
module sram_loader #(
    parameter logic [7:0] BASE   = 8'h00,
    parameter bit         VERIFY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] sram_addr,
    output logic       sram_cen,
    output logic       sram_wen,
    output logic       sram_oen,
    inout  wire  [7:0] sram_dq,
    output logic       cpu_reset_n,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] checksum
);

    typedef enum logic [2:0] {
        IDLE, WAIT, WSETUP, WSTROBE, WHOLD, RSETUP, RCAP, FINISH
    } state_t;

    state_t     state;
    logic [7:0] ptr;
    logic [7:0] data_q;
    logic [7:0] rsum;
    logic [8:0] count;
    logic [8:0] total;
    logic       den;

    logic [8:0] count_inc;
    logic       last_byte;
    logic       finish_err;

    assign count_inc  = count + 9'd1;
    assign last_byte  = (count_inc == total);
    assign finish_err = VERIFY && (rsum != checksum);

    // The loader only drives the bus while a write is set up, strobed or held.
    assign sram_dq = den ? data_q : 8'hzz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            sram_addr   <= 8'h00;
            sram_cen    <= 1'b1;
            sram_wen    <= 1'b1;
            sram_oen    <= 1'b1;
            den         <= 1'b0;
            cpu_reset_n <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            checksum    <= 8'h00;
            ptr         <= BASE;
            count       <= 9'd0;
            total       <= 9'd0;
            data_q      <= 8'h00;
            rsum        <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        total       <= (len == 8'h00) ? 9'd256 : {1'b0, len};
                        ptr         <= BASE;
                        count       <= 9'd0;
                        checksum    <= 8'h00;
                        err         <= 1'b0;
                        busy        <= 1'b1;
                        cpu_reset_n <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (in_valid) begin
                        data_q    <= in_data;
                        checksum  <= checksum + in_data;
                        in_ready  <= 1'b0;
                        sram_addr <= ptr;
                        den       <= 1'b1;
                        state     <= WSETUP;
                    end
                end
                WSETUP: begin
                    sram_cen <= 1'b0;
                    sram_wen <= 1'b0;
                    state    <= WSTROBE;
                end
                WSTROBE: begin
                    sram_cen <= 1'b1;
                    sram_wen <= 1'b1;
                    state    <= WHOLD;
                end
                WHOLD: begin
                    den   <= 1'b0;
                    ptr   <= ptr + 8'd1;
                    count <= count_inc;
                    if (!last_byte) begin
                        in_ready <= 1'b1;
                        state    <= WAIT;
                    end else if (VERIFY) begin
                        // Readback restarts from BASE with a fresh count and sum.
                        ptr       <= BASE;
                        count     <= 9'd0;
                        rsum      <= 8'h00;
                        sram_addr <= BASE;
                        sram_cen  <= 1'b0;
                        sram_oen  <= 1'b0;
                        state     <= RSETUP;
                    end else begin
                        state <= FINISH;
                    end
                end
                RSETUP: begin
                    rsum     <= rsum + sram_dq;
                    sram_cen <= 1'b1;
                    sram_oen <= 1'b1;
                    ptr      <= ptr + 8'd1;
                    count    <= count_inc;
                    state    <= RCAP;
                end
                RCAP: begin
                    if (count == total) begin
                        state <= FINISH;
                    end else begin
                        sram_addr <= ptr;
                        sram_cen  <= 1'b0;
                        sram_oen  <= 1'b0;
                        state     <= RSETUP;
                    end
                end
                FINISH: begin
                    done        <= 1'b1;
                    err         <= finish_err;
                    cpu_reset_n <= !finish_err;
                    busy        <= 1'b0;
                    sram_addr   <= BASE;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
